acc_adapter: RTL and testbench
==============================

Name: acc_adapter

Overview:
Bridges a core's accelerator-offload port to the shared accelerator interconnect. Broadcasts each offloaded instruction word to all predecoders and selects the accepting one by fixed priority. Assembles operands and the routing address from that predecoder's response, then forwards the request upstream. Instructions no predecoder claims are rejected to the core; interconnect responses pass back to the core unchanged.

Parameters:
- DataWidth, 32, operand/result width.
- NumHier, 3, number of interconnect hierarchy levels.
- NumRsp, '{4,2,2}, predecoders/accelerators per hierarchy level (unpacked int array [NumHier]).
- NumRspTot, sum(NumRsp) = 8, derived; total predecoders.
- HierAddrWidth / AccAddrWidth, idx_width(NumHier)=2 / idx_width(max NumRsp)=2, derived.
- AddrWidth, HierAddrWidth+AccAddrWidth = 4, derived.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- mst_q_instr_data  in  32  offloaded instruction
- mst_q_rs  in  3*DataWidth  source operands rs1,rs2,rs3 ([i*DW+:DW])
- mst_q_valid  in  1  core request valid
- mst_q_ready  out  1  request consumed (accepted or rejected)
- mst_k_accept  out  1  qualifies mst_q_ready: 1=offloaded, 0=rejected
- mst_k_writeback  out  1  accepting predecoder's writeback flag
- mst_p_data  out  DataWidth  result to core
- mst_p_valid  out  1  result valid
- mst_p_ready  in  1  core takes result
- prd_q_instr_data  out  32  broadcast to all predecoders
- prd_k_accept  in  NumRspTot  per-predecoder accept
- prd_k_op_select  in  NumRspTot*6  per predecoder, 3 fields x 2 bits
- prd_k_writeback  in  NumRspTot  per-predecoder writeback flag
- slv_q_addr  out  AddrWidth  {hier_idx, acc_idx}
- slv_q_instr_data  out  32  forwarded instruction
- slv_q_data_op  out  3*DataWidth  assembled operands
- slv_q_id  out  1  constant 0
- slv_q_valid / slv_q_ready  out/in  1  interconnect request handshake
- slv_p_data  in  DataWidth  interconnect result
- slv_p_valid / slv_p_ready  in/out  1  interconnect response handshake

Behaviour:
- prd_q_instr_data = mst_q_instr_data, combinational, always driven.
- Winner k = lowest index with prd_k_accept[k]=1. hit = |prd_k_accept.
- Address: h = level containing flat index k, local = k - sum(NumRsp[0..h-1]); slv_q_addr = {h, local}. Examples: k=5 -> 4'b0101; k=7 -> 4'b1001.
- Operand j = op_select field [k*6+j*2+:2]: 00 -> 0, 01 -> rs1, 10 -> rs2, 11 -> rs3.
- Forwarded fields: slv_q_instr_data = mst_q_instr_data; mst_k_writeback = prd_k_writeback[k].
- Reject (valid & !hit): mst_q_ready=1 and mst_k_accept=0 in the same cycle. Nothing is sent upstream. Independent of slv_q_ready.
- Accept (valid & hit): slv_q_valid=1, mst_k_accept=1, mst_q_ready = upstream ready (see Optional Feature).
- When mst_q_valid=0: mst_q_ready=0, slv_q_valid=0 (base mode).
- Response path: mst_p_* = slv_p_*, slv_p_ready = mst_p_ready, combinational.
- Core must hold its request stable while valid and not ready. Predecoder responses are combinational functions of the broadcast instruction.

Optional Feature:
- ACC_ADAPTER_CUT_EN defined: a one-entry pipeline register on the accepted-request path, holding addr, instr_data, data_op and valid.
  - Accept: mst_q_ready = !full | slv_q_ready; full throughput; latency 1 cycle.
  - Reset: register empty, so slv_q_valid=0 and data outputs 0.
  - Reset mid-transfer drops the held entry.
  - Rejects remain same-cycle, even while the register is full.
- ACC_ADAPTER_CUT_EN undefined: fully combinational, zero latency, mst_q_ready = slv_q_ready on accept. The design holds no state and rst_n is unused.

Decomposition:
- Package acc_adapter_pkg holds: op_select encoding constants; sumn/maxn helper functions; the hierarchy-offset computation; the req/rsp struct typedefs.
- One sub-module, acc_adapter_prio_sel: lowest-index priority encoder producing hit, k, and the {h, local} address.

Test Plan:
- Only predecoder 5 accepts, op_select {rs1=01, rs2=10, rs3=11}, rs={A,B,C} -> slv_q_addr=4'b0101, data_op={A,B,C}, instr_data forwarded unchanged, mst_k_accept=1.
- Predecoders 2 and 7 both accept -> k=2, addr=4'b0010. With 7 alone -> addr=4'b1001.
- No accept, slv_q_ready=0 -> mst_q_ready=1, mst_k_accept=0, slv_q_valid=0 in the same cycle.
- op_select 00 on all operands -> data_op all zero. Fields {11,11,01} -> {C,C,A}.
- Accept with slv_q_ready held low 3 cycles -> request held stable, mst_q_ready=0 until the ready cycle, then exactly one transfer.
- slv_p_valid=1 with data 0xDEADBEEF, mst_p_ready=0 then 1 -> passed through unchanged, back-pressure honoured.
- Regression: 1000 random requests with random accept/op_select; each accepted request matches the address/operand model, and each rejected request had no accept asserted.

Source files
------------

// File: rtl/acc_adapter_pkg.sv
// Shared constants, hierarchy helpers and request/response types for acc_adapter.
// Optional macro ACC_ADAPTER_CUT_EN (used by acc_adapter.sv) adds a request pipeline stage.
package acc_adapter_pkg;

  localparam int DataWidth  = 32;
  localparam int InstrWidth = 32;
  localparam int NumOps     = 3;
  localparam int NumHier    = 3;
  localparam int NumRsp [NumHier] = '{4, 2, 2};

  typedef enum logic [1:0] {
    OP_ZERO = 2'b00,
    OP_RS1  = 2'b01,
    OP_RS2  = 2'b10,
    OP_RS3  = 2'b11
  } op_sel_e;

  localparam int OpSelWidth = 2;
  localparam int OpSelPerPrd = NumOps * OpSelWidth;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sum of predecoder counts over levels [0, n).
  function automatic int sumn(input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) s += NumRsp[i];
    return s;
  endfunction

  function automatic int maxn();
    int m;
    m = 0;
    for (int i = 0; i < NumHier; i++) if (NumRsp[i] > m) m = NumRsp[i];
    return m;
  endfunction

  // Flat index of the first predecoder belonging to hierarchy level h.
  function automatic int hier_offset(input int h);
    return sumn(h);
  endfunction

  localparam int NumRspTot     = sumn(NumHier);
  localparam int IdxWidth      = idx_width(NumRspTot);
  localparam int HierAddrWidth = idx_width(NumHier);
  localparam int AccAddrWidth  = idx_width(maxn());
  localparam int AddrWidth     = HierAddrWidth + AccAddrWidth;

  typedef struct packed {
    logic [AddrWidth-1:0]        addr;
    logic [InstrWidth-1:0]       instr_data;
    logic [NumOps*DataWidth-1:0] data_op;
  } acc_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
  } acc_rsp_t;

  function automatic logic [DataWidth-1:0] select_operand(
    input op_sel_e                     sel,
    input logic [NumOps*DataWidth-1:0] rs
  );
    case (sel)
      OP_RS1:  return rs[0*DataWidth +: DataWidth];
      OP_RS2:  return rs[1*DataWidth +: DataWidth];
      OP_RS3:  return rs[2*DataWidth +: DataWidth];
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/acc_adapter_prio_sel.sv
// Lowest-index priority select over predecoder accepts; yields the winner index
// and its {hierarchy level, local index} interconnect address.
module acc_adapter_prio_sel
  import acc_adapter_pkg::*;
(
  input  logic [NumRspTot-1:0] i_accept,
  output logic                 o_hit,
  output logic [IdxWidth-1:0]  o_idx,
  output logic [AddrWidth-1:0] o_addr
);

  logic                     w_hit;
  logic [IdxWidth-1:0]      w_idx;
  logic [HierAddrWidth-1:0] w_hier;
  logic [AccAddrWidth-1:0]  w_local;

  // Scan downwards so the lowest set index is the last assignment.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NumRspTot - 1; i >= 0; i--) begin
      if (i_accept[i]) begin
        w_hit = 1'b1;
        w_idx = IdxWidth'(i);
      end
    end
  end

  // The highest level whose first flat index does not exceed the winner owns it.
  always_comb begin
    w_hier  = '0;
    w_local = '0;
    for (int h = 0; h < NumHier; h++) begin
      if (int'(w_idx) >= hier_offset(h)) begin
        w_hier  = HierAddrWidth'(h);
        w_local = AccAddrWidth'(int'(w_idx) - hier_offset(h));
      end
    end
  end

  assign o_hit  = w_hit;
  assign o_idx  = w_idx;
  assign o_addr = {w_hier, w_local};

endmodule

// File: rtl/acc_adapter.sv
// Core accelerator-offload port to interconnect bridge.
// ACC_ADAPTER_CUT_EN: one-entry register on the accepted-request path (else fully combinational).
module acc_adapter
  import acc_adapter_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [InstrWidth-1:0]         mst_q_instr_data,
  input  logic [NumOps*DataWidth-1:0]   mst_q_rs,
  input  logic                          mst_q_valid,
  output logic                          mst_q_ready,
  output logic                          mst_k_accept,
  output logic                          mst_k_writeback,
  output logic [DataWidth-1:0]          mst_p_data,
  output logic                          mst_p_valid,
  input  logic                          mst_p_ready,
  output logic [InstrWidth-1:0]         prd_q_instr_data,
  input  logic [NumRspTot-1:0]          prd_k_accept,
  input  logic [NumRspTot*OpSelPerPrd-1:0] prd_k_op_select,
  input  logic [NumRspTot-1:0]          prd_k_writeback,
  output logic [AddrWidth-1:0]          slv_q_addr,
  output logic [InstrWidth-1:0]         slv_q_instr_data,
  output logic [NumOps*DataWidth-1:0]   slv_q_data_op,
  output logic                          slv_q_id,
  output logic                          slv_q_valid,
  input  logic                          slv_q_ready,
  input  logic [DataWidth-1:0]          slv_p_data,
  input  logic                          slv_p_valid,
  output logic                          slv_p_ready
);

  // Handshakes: a request transfers on a cycle with valid & ready both high; the
  // core holds its request stable until mst_q_ready, and mst_k_accept tells it
  // whether that cycle offloaded (1) or rejected (0) the instruction.

  logic                        w_hit;
  logic [IdxWidth-1:0]         w_idx;
  logic [AddrWidth-1:0]        w_addr;
  logic [NumOps*DataWidth-1:0] w_data_op;
  logic                        w_accept_req;
  logic                        w_reject_req;
  logic                        w_up_ready;
  acc_req_t                    w_req;

  assign prd_q_instr_data = mst_q_instr_data;

  acc_adapter_prio_sel u_prio_sel (
    .i_accept (prd_k_accept),
    .o_hit    (w_hit),
    .o_idx    (w_idx),
    .o_addr   (w_addr)
  );

  always_comb begin
    w_data_op = '0;
    for (int j = 0; j < NumOps; j++) begin
      w_data_op[j*DataWidth +: DataWidth] = select_operand(
        op_sel_e'(prd_k_op_select[int'(w_idx)*OpSelPerPrd + j*OpSelWidth +: OpSelWidth]),
        mst_q_rs);
    end
  end

  assign w_accept_req    = mst_q_valid & w_hit;
  assign w_reject_req    = mst_q_valid & ~w_hit;
  assign w_req           = '{addr: w_addr, instr_data: mst_q_instr_data, data_op: w_data_op};
  assign mst_k_accept    = w_accept_req;
  assign mst_k_writeback = w_hit & prd_k_writeback[w_idx];
  // Rejects never wait on the interconnect.
  assign mst_q_ready     = w_reject_req | (w_accept_req & w_up_ready);

`ifdef ACC_ADAPTER_CUT_EN
  acc_req_t r_req;
  logic     r_full;

  assign w_up_ready = ~r_full | slv_q_ready;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_full <= 1'b0;
      r_req  <= '0;
    end else if (w_accept_req && w_up_ready) begin
      r_full <= 1'b1;
      r_req  <= w_req;
    end else if (slv_q_ready) begin
      r_full <= 1'b0;
    end
  end

  assign slv_q_valid      = r_full;
  assign slv_q_addr       = r_req.addr;
  assign slv_q_instr_data = r_req.instr_data;
  assign slv_q_data_op    = r_req.data_op;
`else
  logic w_unused_clk_rst;

  // Purely combinational build: clock and reset are not needed.
  assign w_unused_clk_rst = clk ^ rst_n;
  assign w_up_ready       = slv_q_ready;
  assign slv_q_valid      = w_accept_req;
  assign slv_q_addr       = w_req.addr;
  assign slv_q_instr_data = w_req.instr_data;
  assign slv_q_data_op    = w_req.data_op;
`endif

  assign slv_q_id    = 1'b0;
  assign mst_p_data  = slv_p_data;
  assign mst_p_valid = slv_p_valid;
  assign slv_p_ready = mst_p_ready;

endmodule

// File: tb/tb_acc_adapter.sv
// Bench for acc_adapter: directed steps plus a randomized regression against a
// table-driven reference model; interconnect transfers are scoreboarded.
module tb_acc_adapter;

  localparam int DW = 32;
  localparam int NT = 8;
  localparam int EW = 4 + 32 + 3*DW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [31:0]       mst_q_instr_data = '0;
  logic [3*DW-1:0]   mst_q_rs = '0;
  logic              mst_q_valid = 1'b0;
  logic              mst_q_ready;
  logic              mst_k_accept;
  logic              mst_k_writeback;
  logic [DW-1:0]     mst_p_data;
  logic              mst_p_valid;
  logic              mst_p_ready = 1'b0;
  logic [31:0]       prd_q_instr_data;
  logic [NT-1:0]     prd_k_accept = '0;
  logic [NT*6-1:0]   prd_k_op_select = '0;
  logic [NT-1:0]     prd_k_writeback = '0;
  logic [3:0]        slv_q_addr;
  logic [31:0]       slv_q_instr_data;
  logic [3*DW-1:0]   slv_q_data_op;
  logic              slv_q_id;
  logic              slv_q_valid;
  logic              slv_q_ready = 1'b0;
  logic [DW-1:0]     slv_p_data = '0;
  logic              slv_p_valid = 1'b0;
  logic              slv_p_ready;

  int total = 0;
  int bad = 0;
  int n_xfer = 0;
  int n_pushed = 0;
  bit mon_en = 1'b0;
  logic [EW-1:0] exp_q[$];
  int lvl_cnt [3] = '{4, 2, 2};

  always #5 clk = ~clk;

  acc_adapter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mst_q_instr_data (mst_q_instr_data),
    .mst_q_rs         (mst_q_rs),
    .mst_q_valid      (mst_q_valid),
    .mst_q_ready      (mst_q_ready),
    .mst_k_accept     (mst_k_accept),
    .mst_k_writeback  (mst_k_writeback),
    .mst_p_data       (mst_p_data),
    .mst_p_valid      (mst_p_valid),
    .mst_p_ready      (mst_p_ready),
    .prd_q_instr_data (prd_q_instr_data),
    .prd_k_accept     (prd_k_accept),
    .prd_k_op_select  (prd_k_op_select),
    .prd_k_writeback  (prd_k_writeback),
    .slv_q_addr       (slv_q_addr),
    .slv_q_instr_data (slv_q_instr_data),
    .slv_q_data_op    (slv_q_data_op),
    .slv_q_id         (slv_q_id),
    .slv_q_valid      (slv_q_valid),
    .slv_q_ready      (slv_q_ready),
    .slv_p_data       (slv_p_data),
    .slv_p_valid      (slv_p_valid),
    .slv_p_ready      (slv_p_ready)
  );

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: first claiming predecoder, its level/local address, operand picks.
  function automatic int m_winner(input logic [NT-1:0] acc);
    for (int i = 0; i < NT; i++) if (acc[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] m_addr(input int k);
    int h;
    int base;
    logic [1:0] hh;
    logic [1:0] ll;
    h = 0;
    base = 0;
    while (h < 2 && k >= base + lvl_cnt[h]) begin
      base += lvl_cnt[h];
      h++;
    end
    hh = h[1:0];
    ll = 2'(k - base);
    return {hh, ll};
  endfunction

  function automatic logic [3*DW-1:0] m_ops(input int k, input logic [NT*6-1:0] ops,
                                            input logic [3*DW-1:0] rs);
    logic [3*DW-1:0] r;
    int sel;
    r = '0;
    for (int j = 0; j < 3; j++) begin
      sel = int'(ops[k*6 + j*2 +: 2]);
      if (sel != 0) r[j*DW +: DW] = rs[(sel-1)*DW +: DW];
    end
    return r;
  endfunction

  task automatic present(input logic [31:0] instr, input logic [3*DW-1:0] rs,
                         input logic [NT-1:0] acc, input logic [NT*6-1:0] ops,
                         input logic [NT-1:0] wb);
    int k;
    mst_q_instr_data = instr;
    mst_q_rs         = rs;
    prd_k_accept     = acc;
    prd_k_op_select  = ops;
    prd_k_writeback  = wb;
    mst_q_valid      = 1'b1;
    k = m_winner(acc);
    if (k >= 0) begin
      exp_q.push_back({m_addr(k), instr, m_ops(k, ops, rs)});
      n_pushed++;
    end
  endtask

  always @(negedge clk) begin
    #3;
    if (mon_en && slv_q_valid && slv_q_ready) begin
      n_xfer++;
      chk("xfer_expected", EW'(exp_q.size() != 0), EW'(1));
      if (exp_q.size() != 0)
        chk("xfer_payload", {slv_q_addr, slv_q_instr_data, slv_q_data_op}, exp_q.pop_front());
    end
  end

  logic [31:0]     va, vb, vc;
  logic [31:0]     r_instr;
  logic [3*DW-1:0] r_rs;
  logic [NT-1:0]   r_acc;
  logic [NT*6-1:0] r_ops;
  logic [NT-1:0]   r_wb;
  int              k;
  int              waits;
  bit              done;
  int              x0;

  initial begin
    va = 32'h1111_AAAA;
    vb = 32'h2222_BBBB;
    vc = 32'h3333_CCCC;

    @(negedge clk);
    #1;
    chk("rst_q_ready", mst_q_ready, 0);
    chk("rst_slv_valid", slv_q_valid, 0);
    chk("rst_k_accept", mst_k_accept, 0);
    chk("slv_q_id", slv_q_id, 0);
    @(negedge clk);
    rst_n = 1'b0;
    mon_en = 1'b1;

    // Predecoder 5 alone, operands rs1/rs2/rs3 in order.
    @(negedge clk);
    slv_q_ready = 1'b1;
    present(32'hCAFE_0005, {vc, vb, va}, 8'b0010_0000, 48'(6'b11_10_01) << 30, 8'b0010_0000);
    #1;
    chk("k5_addr", slv_q_addr, 4'b0101);
    chk("k5_data_op", slv_q_data_op, {vc, vb, va});
    chk("k5_instr", slv_q_instr_data, 32'hCAFE_0005);
    chk("k5_bcast", prd_q_instr_data, 32'hCAFE_0005);
    chk("k5_accept", mst_k_accept, 1);
    chk("k5_ready", mst_q_ready, 1);
    chk("k5_wb", mst_k_writeback, 1);

    @(negedge clk);
    present(32'h0000_0207, {vc, vb, va}, 8'b1000_0100, '0, '0);
    #1;
    chk("k2_over_k7_addr", slv_q_addr, 4'b0010);
    @(negedge clk);
    present(32'h0000_0007, {vc, vb, va}, 8'b1000_0000, '0, '0);
    #1;
    chk("k7_addr", slv_q_addr, 4'b1001);
    chk("op_all_zero", slv_q_data_op, '0);

    @(negedge clk);
    present(32'h0000_0003, {vc, vb, va}, 8'b0000_1000, 48'(6'b01_11_11) << 18, '0);
    #1;
    chk("op_c_c_a", slv_q_data_op, {va, vc, vc});

    // Reject while upstream stalls.
    @(negedge clk);
    slv_q_ready = 1'b0;
    present(32'hBAD0_0000, {vc, vb, va}, '0, '0, '0);
    #1;
    chk("rej_ready", mst_q_ready, 1);
    chk("rej_accept", mst_k_accept, 0);
    chk("rej_slv_valid", slv_q_valid, 0);

    // Accept held off by upstream for three cycles.
    @(negedge clk);
    x0 = n_xfer;
    present(32'h0000_0001, {vc, vb, va}, 8'b0000_0010, 48'(6'b10_01_11) << 6, '0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_q_ready", mst_q_ready, 0);
      chk("hold_slv_valid", slv_q_valid, 1);
      chk("hold_addr", slv_q_addr, 4'b0001);
      @(negedge clk);
    end
    chk("hold_no_xfer", n_xfer, x0);
    slv_q_ready = 1'b1;
    #1;
    chk("hold_release_ready", mst_q_ready, 1);
    @(negedge clk);
    mst_q_valid = 1'b0;
    #4;
    chk("hold_one_xfer", n_xfer, x0 + 1);
    chk("idle_q_ready", mst_q_ready, 0);
    chk("idle_slv_valid", slv_q_valid, 0);

    // Response pass-through with back-pressure.
    @(negedge clk);
    slv_p_valid = 1'b1;
    slv_p_data  = 32'hDEAD_BEEF;
    mst_p_ready = 1'b0;
    #1;
    chk("rsp_valid", mst_p_valid, 1);
    chk("rsp_data", mst_p_data, 32'hDEAD_BEEF);
    chk("rsp_bp_ready", slv_p_ready, 0);
    @(negedge clk);
    mst_p_ready = 1'b1;
    #1;
    chk("rsp_ready", slv_p_ready, 1);
    chk("rsp_data_hold", mst_p_data, 32'hDEAD_BEEF);
    @(negedge clk);
    slv_p_valid = 1'b0;
    mst_p_ready = 1'b0;

    // Randomized regression.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 4) == 0) begin
        mst_q_valid = 1'b0;
        slv_q_ready = 1'($urandom_range(0, 1));
        #1;
        chk("rnd_idle_ready", mst_q_ready, 0);
        chk("rnd_idle_slv_valid", slv_q_valid, 0);
        @(negedge clk);
      end
      r_instr = $urandom;
      r_rs    = {$urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       r_acc = '0;
        1:       r_acc = NT'(1) << $urandom_range(0, NT - 1);
        default: r_acc = NT'($urandom);
      endcase
      r_ops = {$urandom, $urandom};
      r_wb  = NT'($urandom);
      present(r_instr, r_rs, r_acc, r_ops, r_wb);
      k = m_winner(r_acc);
      waits = 0;
      done = 1'b0;
      while (!done) begin
        slv_q_ready = 1'($urandom_range(0, 1));
        #1;
        chk("rnd_accept", mst_k_accept, EW'(k >= 0));
        if (k < 0) begin
          chk("rnd_rej_ready", mst_q_ready, 1);
          chk("rnd_rej_slv_valid", slv_q_valid, 0);
          done = 1'b1;
        end else begin
          chk("rnd_acc_ready", mst_q_ready, slv_q_ready);
          chk("rnd_acc_slv_valid", slv_q_valid, 1);
          chk("rnd_acc_wb", mst_k_writeback, r_wb[k]);
          done = slv_q_ready;
        end
        waits++;
        if (!done && waits > 64) begin
          chk("rnd_wait_bound", waits, 64);
          done = 1'b1;
        end
        if (!done) @(negedge clk);
      end
    end

    @(negedge clk);
    mst_q_valid = 1'b0;
    @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("xfer_count", n_xfer, n_pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
